// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the byte serialiser and its FIFO.
//   uart_state_t         - transmitter FSM states
//   UART_DATA_BITS       - payload bits per frame (8N1)
//   DEFAULT_CLKS_PER_BIT - default baud divisor
package uart_pkg;

   localparam int UART_DATA_BITS       = 8;
   localparam int DEFAULT_CLKS_PER_BIT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: small synchronous byte FIFO built on a register array.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset (pointers only)
//   push, wdata - write strobe and data; the caller only pushes when not full
//   pop, rdata  - read strobe and head-of-queue data (rdata valid while !empty)
//   full, empty - occupancy flags
//   count       - number of queued entries, 0..DEPTH
module byte_fifo
   import uart_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [UART_DATA_BITS-1:0]   wdata,
   input  logic                        pop,
   output logic [UART_DATA_BITS-1:0]   rdata,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(DEPTH):0]      count
);

   localparam int AW = $clog2(DEPTH);

   logic [UART_DATA_BITS-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty when the
   // address bits coincide.
   logic [AW:0] wr_ptr;
   logic [AW:0] rd_ptr;

   logic do_push;
   logic do_pop;

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign count = wr_ptr - rd_ptr;
   assign rdata = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // Storage carries no reset; contents are only observed behind the pointers.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end

endmodule

// File: rtl/uart_byte_tx.sv
// uart_byte_tx: queues bytes through a valid/ready handshake and sends each
// one as an 8N1 UART frame (start 0, 8 data bits LSB first, stop 1).
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   ena         - tile enable; gates byte acceptance and frame start
//   in_data     - byte to transmit
//   in_valid    - in_data valid this cycle
//   in_ready    - combinational, ena & ~fifo_full
//   tx          - registered serial output, idle high
//   busy        - registered, high from start bit through end of stop bit
//   fifo_count  - bytes currently queued
module uart_byte_tx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           ena,
   input  logic [7:0]                     in_data,
   input  logic                           in_valid,
   output logic                           in_ready,
   output logic                           tx,
   output logic                           busy,
   output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

   localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int BIT_W  = $clog2(UART_DATA_BITS);

   uart_state_t               state;
   logic [BAUD_W-1:0]         baud_cnt;
   logic [BIT_W-1:0]          bit_cnt;
   logic [UART_DATA_BITS-1:0] shift;

   logic                      fifo_full;
   logic                      fifo_empty;
   logic [UART_DATA_BITS-1:0] fifo_rdata;
   logic                      push;
   logic                      pop;
   logic                      start_ok;
   logic                      baud_last;
   logic                      last_bit;
   logic                      shift_step;

   assign in_ready  = ena & ~fifo_full;
   assign push      = in_valid & in_ready;
   assign start_ok  = ena & ~fifo_empty;
   assign baud_last = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
   assign last_bit  = (bit_cnt == BIT_W'(UART_DATA_BITS - 1));

   // A frame may begin straight out of IDLE or on the last stop cycle,
   // which is what makes back-to-back frames gapless.
   assign pop = start_ok & ((state == IDLE) | ((state == STOP) & baud_last));

   assign shift_step = (state == DATA) & baud_last & ~last_bit;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .wdata (in_data),
      .pop   (pop),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Payload shift register: loaded on pop, advanced at each data bit boundary.
   always_ff @(posedge clk) begin
      if (pop)             shift <= fifo_rdata;
      else if (shift_step) shift <= shift >> 1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         tx       <= 1'b1;
         busy     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               tx       <= 1'b1;
               baud_cnt <= '0;
               if (start_ok) begin
                  state <= START;
                  tx    <= 1'b0;
                  busy  <= 1'b1;
               end
            end

            START: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  bit_cnt  <= '0;
                  tx       <= shift[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            DATA: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (last_bit) begin
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     bit_cnt <= bit_cnt + BIT_W'(1);
                     // shift advances on this same edge, so the next bit is shift[1]
                     tx      <= shift[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            STOP: begin
               if (baud_last) begin
                  baud_cnt <= '0;
                  if (start_ok) begin
                     tx    <= 1'b0;
                     state <= START;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + BAUD_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               tx    <= 1'b1;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: directed bench for uart_byte_tx with a frame-decoding
// scoreboard. Accepted bytes are queued as expected frames; a receiver
// process decodes tx and compares each frame against the queue head.
module tb_uart_byte_tx;

   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          ena = 1'b0;
   logic [7:0]    in_data = 8'h00;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          tx;
   logic          busy;
   logic [CW-1:0] fifo_count;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int rst_events = 0;

   logic [7:0] exp_q[$];

   uart_byte_tx #(
      .CLKS_PER_BIT (CPB),
      .FIFO_DEPTH   (DEPTH)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .ena        (ena),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge rst_n) rst_events = rst_events + 1;

   task automatic check(input string name, input int act, input int req);
      tests = tests + 1;
      if (act !== req) begin
         fails = fails + 1;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Drives one byte for a single edge; returns acceptance and the edge index.
   task automatic push_byte(input logic [7:0] b, output bit acc, output int edge_c);
      @(negedge clk);
      in_data  = b;
      in_valid = 1'b1;
      #1 acc = in_ready;
      @(posedge clk);
      #1;
      edge_c   = cyc;
      in_valid = 1'b0;
      if (acc) exp_q.push_back(b);
   endtask

   task automatic wait_idle(input string name, input int maxc);
      int n;
      n = 0;
      while ((busy || fifo_count != 0) && n < maxc) begin
         @(negedge clk);
         n++;
      end
      check(name, int'(busy == 1'b0 && fifo_count == 0), 1);
   endtask

   // Receiver: samples each bit at its middle, counted from the first low sample.
   bit         rx_active = 1'b0;
   int         rx_cnt = 0;
   int         rx_seen_rst = 0;
   logic [7:0] rx_byte = 8'h00;
   logic [7:0] rx_exp;

   always @(negedge clk) begin
      int s;
      int k;
      if (rx_seen_rst != rst_events) begin
         rx_seen_rst = rst_events;
         rx_active   = 1'b0;
      end else if (rst_n) begin
         if (!rx_active) begin
            if (tx == 1'b0) begin
               rx_active = 1'b1;
               rx_cnt    = 1;
            end
         end else begin
            rx_cnt = rx_cnt + 1;
            s = rx_cnt - 1 - CPB / 2;
            if (s >= 0 && (s % CPB) == 0) begin
               k = s / CPB;
               if (k == 0) begin
                  if (tx != 1'b0) rx_active = 1'b0;
               end else if (k <= 8) begin
                  rx_byte[k-1] = tx;
               end else begin
                  check("sb_stop", int'(tx), 1);
                  check("sb_pending", int'(exp_q.size() != 0), 1);
                  if (exp_q.size() != 0) begin
                     rx_exp = exp_q.pop_front();
                     check("sb_byte", int'(rx_byte), int'(rx_exp));
                  end
                  rx_active = 1'b0;
               end
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got cycle %0d, required finish", cyc);
      $fatal(1, "timeout");
   end

   initial begin
      bit         a;
      int         e;
      int         ed;
      int         cnt;
      int         et;
      logic [7:0] b1;
      logic [7:0] t3v [6];

      // Reset state
      ena = 1'b1;
      #12;
      check("rst_tx", int'(tx), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_count", int'(fifo_count), 0);
      check("rst_ready_ena1", int'(in_ready), 1);
      ena = 1'b0;
      #1 check("rst_ready_ena0", int'(in_ready), 0);
      ena = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);

      // 1: single byte timing
      b1 = 8'hA5;
      push_byte(b1, a, e);
      check("t1_acc", int'(a), 1);
      @(negedge clk);
      check("t1_count", int'(fifo_count), 1);
      check("t1_tx_idle", int'(tx), 1);
      for (int c = 1; c <= 41; c++) begin
         @(negedge clk);
         if (c <= 4)       et = 0;
         else if (c <= 36) et = int'(b1[(c - 5) / 4]);
         else              et = 1;
         check("t1_tx", int'(tx), et);
         check("t1_busy", int'(busy), (c <= 40) ? 1 : 0);
      end
      repeat (3) @(negedge clk);

      // 2: back-to-back frames
      push_byte(8'h00, a, e);
      push_byte(8'hFF, a, ed);
      push_byte(8'h3C, a, ed);
      cnt = 0;
      while (cyc < e + 121) begin
         @(negedge clk);
         if (cyc >= e + 1 && cyc <= e + 120 && busy != 1'b1) cnt++;
      end
      check("t2_gaps", cnt, 0);
      check("t2_end_busy", int'(busy), 0);
      check("t2_end_tx", int'(tx), 1);
      repeat (3) @(negedge clk);

      // 3: full FIFO
      t3v[0] = 8'h01; t3v[1] = 8'h02; t3v[2] = 8'h80;
      t3v[3] = 8'h7E; t3v[4] = 8'hAA; t3v[5] = 8'h55;
      push_byte(8'h11, a, e);
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin
         push_byte(t3v[i], a, ed);
         check("t3_acc", int'(a), (i < 4) ? 1 : 0);
      end
      check("t3_count", int'(fifo_count), 4);
      check("t3_ready", int'(in_ready), 0);
      wait_idle("t3_drain", 400);
      repeat (3) @(negedge clk);

      // 4: simultaneous push/pop at count 1
      push_byte(8'hC3, a, e);
      push_byte(8'h96, a, ed);
      check("t4_count_a", int'(fifo_count), 1);
      while (cyc != e + 39) @(negedge clk);
      push_byte(8'h5A, a, ed);
      check("t4_edge", ed, e + 41);
      check("t4_count_b", int'(fifo_count), 1);
      check("t4_busy", int'(busy), 1);
      check("t4_tx_start", int'(tx), 0);
      wait_idle("t4_drain", 300);
      repeat (3) @(negedge clk);

      // 5: ena low mid-frame
      push_byte(8'hA1, a, e);
      push_byte(8'hB2, a, ed);
      push_byte(8'hC3, a, ed);
      while (cyc != e + 10) @(negedge clk);
      ena = 1'b0;
      #1 check("t5_ready", int'(in_ready), 0);
      cnt = 0;
      while (cyc != e + 60) begin
         @(negedge clk);
         if (cyc >= e + 41 && tx != 1'b1) cnt++;
      end
      check("t5_tx_held", cnt, 0);
      check("t5_busy", int'(busy), 0);
      check("t5_count", int'(fifo_count), 2);
      ena = 1'b1;
      @(negedge clk);
      check("t5_restart_tx", int'(tx), 0);
      check("t5_restart_busy", int'(busy), 1);
      check("t5_restart_count", int'(fifo_count), 1);
      wait_idle("t5_drain", 300);
      repeat (3) @(negedge clk);

      // 6: reset mid-frame
      push_byte(8'h00, a, e);
      push_byte(8'h18, a, ed);
      while (cyc != e + 12) @(negedge clk);
      check("t6_pre_tx", int'(tx), 0);
      #1 rst_n = 1'b0;
      #1;
      check("t6_rst_tx", int'(tx), 1);
      check("t6_rst_busy", int'(busy), 0);
      check("t6_rst_count", int'(fifo_count), 0);
      check("t6_rst_ready", int'(in_ready), 1);
      #1 rst_n = 1'b1;
      exp_q.delete();
      cnt = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (tx != 1'b1 || busy != 1'b0) cnt++;
      end
      check("t6_quiet", cnt, 0);

      check("sb_drain", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_byte_tx.md
Name: uart_byte_tx

Overview:
Downstream serialiser for the tile's registered output byte. It accepts bytes through a valid/ready handshake into a small FIFO and transmits each byte as an 8N1 UART frame on a single registered pin. The top-level wrapper feeds it from the registered output path and routes `tx` to one `uo_out` bit.

Parameters:
- CLKS_PER_BIT, 16, clock cycles per UART bit; legal range ≥2.
- FIFO_DEPTH, 4, byte FIFO entries; must be a power of 2, ≥2.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- ena  in  1  tile enable; gates acceptance and frame start
- in_data  in  8  byte to transmit
- in_valid  in  1  in_data is valid this cycle
- in_ready  out  1  block can accept; combinational, = ena & ~fifo_full
- tx  out  1  UART serial output, registered, idle high
- busy  out  1  registered; 1 from start bit through end of stop bit
- fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued

Behaviour:
- Clock and reset: one clock, `clk`. Reset is asynchronous, active-low `rst_n`. Asserting `rst_n` low clears all state immediately, independent of `clk`.
- Reset values:
  - tx=1, busy=0, fifo_count=0, FSM=IDLE.
  - Baud and bit counters = 0; FIFO pointers = 0; FIFO contents don't-care.
  - in_ready follows `ena` while the FIFO is empty.
- Push: occurs on an edge where in_valid & in_ready. When the FIFO is full, in_ready=0; no pass-through, no overwrite.
- Pop: performed only by the FSM, when leaving IDLE or STOP with the FIFO non-empty and ena=1.
- Push and pop on the same edge: fifo_count unchanged. Data ordering is strictly FIFO.
- FSM states:
  - IDLE: tx=1.
  - START: tx=0.
  - DATA: tx=shift[0], 8 bits, LSB first.
  - STOP: tx=1.
  - Each of START, each DATA bit and STOP lasts exactly CLKS_PER_BIT cycles, timed by the baud counter. The baud counter runs 0..CLKS_PER_BIT-1 and wraps; the bit counter runs 0..7.
- Transitions:
  - IDLE→START: on the edge where the FIFO is non-empty and ena=1. That edge pops, loads the shift register, drives tx←0 and sets busy←1.
  - START→DATA: after CLKS_PER_BIT cycles.
  - DATA→STOP: after bit 7 completes.
  - STOP→START: on the final stop cycle, if the FIFO is non-empty and ena=1. This gives back-to-back frames with no idle gap.
  - STOP→IDLE: on the final stop cycle otherwise, with busy←0.
- Latency: a byte accepted on edge E into an empty FIFO with the FSM in IDLE is popped on edge E+1. tx is low from E+1 to E+1+CLKS_PER_BIT.
- Frame length: 10*CLKS_PER_BIT cycles.
- ena deasserted mid-frame:
  - The current frame completes unchanged.
  - No new frame starts; queued bytes are retained.
  - in_ready=0.
- Reset mid-frame: tx returns to 1 asynchronously, the FIFO empties and the partial frame is abandoned.
- Timing isolation: tx has no combinational path from any input.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state enum: IDLE, START, DATA, STOP.
  - Constant UART_DATA_BITS=8.
  - Default CLKS_PER_BIT.
- Sub-module `byte_fifo` (parameter DEPTH):
  - Interface: push, pop, wdata, rdata, full, empty, count.
  - Storage is a register array. Pointers are $clog2(DEPTH)+1 bits wide, and wrap-around is detected by the pointer MSB.
  - Reset is the same asynchronous active-low reset.
- Top `uart_byte_tx`: FSM, baud counter, bit counter and shift register.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=4):
1. Single byte: push 0xA5 at edge E.
   - tx=0 for cycles E+1..E+4.
   - Data bits 1,0,1,0,0,1,0,1, 4 cycles each.
   - Stop bit =1 for 4 cycles; busy falls at E+41.
2. Back-to-back: push 0x00, 0xFF, 0x3C consecutively.
   - Three frames, 120 cycles total, no idle cycles between stop and start.
   - Decoded bytes arrive in order.
3. Full FIFO: with ena=1, push 6 bytes while the first frame is in flight.
   - in_ready=0 once fifo_count=4.
   - Rejected pushes are ignored; all 5 accepted bytes are transmitted in order.
4. Simultaneous push/pop: push on the exact edge the FSM pops from count=1.
   - fifo_count stays 1; no byte is lost or duplicated.
5. ena low mid-frame: drop ena during DATA with 2 bytes queued.
   - Current frame finishes; tx then holds 1; fifo_count stays 2.
   - Re-raising ena starts the next frame one edge later.
6. Reset mid-frame: pulse rst_n low during DATA, between clock edges.
   - tx=1, busy=0 and fifo_count=0 immediately.
   - After release, tx stays idle with no spurious frame.
